out_port_tx: RTL and testbench

//  Output-direction counterpart of the CPU's IN data path. Captures 16-bit words produced by OUT instructions
//  and transmits them to an external device over a valid/ready handshake. Buffers up to DEPTH words.

---
 rtl/out_port_pkg.sv | 7 +
 rtl/out_fifo_mem.sv | 24 ++
 rtl/out_port_tx.sv | 101 ++++++++++
 tb/tb_out_port_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared types and defaults for the OUT-instruction transmit path.
package out_port_pkg;
  localparam int WORD_W        = 16;
  localparam int OUT_DEPTH_DEF = 4;

  typedef logic [WORD_W-1:0] word_t;
endpackage : out_port_pkg

// File: rtl/out_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port.
module out_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdat,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdat
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage is never reset; the reader gates out stale entries via level.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdat;
    end
  end

  assign rdat = mem_r[raddr];
endmodule : out_fifo_mem

// File: rtl/out_port_tx.sv
// Buffers words written by OUT instructions and hands them to an external device over valid/ready.
// Optional feature macro: OUT_PORT_TXCNT_EN adds a free-running 16-bit tx_count of delivered words.
module out_port_tx
  import out_port_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = OUT_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             out_we,
  input  logic [WIDTH-1:0] out_wdat,
  output logic             stall_out,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level
`ifdef OUT_PORT_TXCNT_EN
  ,
  output logic [15:0]      tx_count
`endif
);
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] rdat_s;

  // Full/empty come from the occupancy count so wrapped pointers never alias.
  assign full_s  = (level_r == LW'(DEPTH));
  assign empty_s = (level_r == {LW{1'b0}});
  assign push_s  = out_we & ~full_s & ~flush;
  assign pop_s   = ~empty_s & out_ready & ~flush;

  // A write that coincides with flush is dropped, so it never needs holding.
  assign stall_out = out_we & full_s & ~flush;
  assign out_valid = ~empty_s;
  assign out_dat   = empty_s ? {WIDTH{1'b0}} : rdat_s;
  assign level     = level_r;

  out_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wptr_r),
    .wdat  (out_wdat),
    .raddr (rptr_r),
    .rdat  (rdat_s)
  );

  // Pointer and occupancy state; flush wins over any push/pop on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      level_r <= {LW{1'b0}};
    end else if (flush) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      level_r <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef OUT_PORT_TXCNT_EN
  logic [15:0] tx_count_r;

  // Delivered-word counter survives flush and wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_r <= 16'h0000;
    end else if (pop_s) begin
      tx_count_r <= tx_count_r + 16'h0001;
    end else begin
      tx_count_r <= tx_count_r;
    end
  end

  assign tx_count = tx_count_r;
`endif
endmodule : out_port_tx

// File: tb/tb_out_port_tx.sv
// Randomized and directed bench for out_port_tx against a queue-based reference model.
module tb_out_port_tx;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          out_we = 1'b0;
  logic [15:0]   out_wdat = 16'h0000;
  logic          stall_out;
  logic [15:0]   out_dat;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
`ifdef OUT_PORT_TXCNT_EN
  logic [15:0]   tx_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_q[$];
  logic [15:0] model_cnt = 16'h0000;

  out_port_tx #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .out_we    (out_we),
    .out_wdat  (out_wdat),
    .stall_out (stall_out),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
`ifdef OUT_PORT_TXCNT_EN
    ,
    .tx_count  (tx_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step(input logic we, input logic [15:0] wd, input logic rdy, input logic fl);
    int sz;
    out_we   = we;
    out_wdat = wd;
    out_ready = rdy;
    flush    = fl;
    @(negedge clk);
    sz = model_q.size();
    chk("level", 32'(level), 32'(sz));
    chk("valid", 32'(out_valid), 32'(sz != 0));
    chk("dat", 32'(out_dat), (sz != 0) ? 32'(model_q[0]) : 32'h0);
    chk("stall", 32'(stall_out), 32'(we && !fl && sz == DEPTH));
`ifdef OUT_PORT_TXCNT_EN
    chk("txcnt", 32'(tx_count), 32'(model_cnt));
`endif
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (rdy && sz > 0) begin
        void'(model_q.pop_front());
        model_cnt = model_cnt + 16'h0001;
      end
      if (we && sz < DEPTH) model_q.push_back(wd);
    end
    #1;
  endtask

  initial begin
    logic [15:0] w;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_dat", 32'(out_dat), 32'h0);

    // single word round trip
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_dat", 32'(out_dat), 32'h1234);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // back-pressure: 5th write stalls until the first pop frees a slot
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("bp_level", 32'(level), 32'h4);
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b1, 16'h0005, 1'b1, 1'b0);
    step(1'b1, 16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // streaming, pointers wrap several times
    for (int i = 0; i < 20; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // flush discards buffered words and the concurrent write
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hA0 + i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("flush_level", 32'(level), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = 16'($urandom);
      step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-cycle with two words held
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    out_we = 1'b0;
    @(negedge clk);
    chk("pre_rst_level", 32'(level), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_dat", 32'(out_dat), 32'h0);
    chk("arst_level", 32'(level), 32'h0);
    model_q.delete();
    model_cnt = 16'h0000;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef OUT_PORT_TXCNT_EN
    // drive the counter up to 65535, then one more pop wraps it
    while (model_cnt != 16'hFFFF) step(1'b1, model_cnt, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("cnt_wrap", 32'(tx_count), 32'h0);
    step(1'b1, 16'h0042, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("cnt_flush_keep", 32'(tx_count), 32'h0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule : tb_out_port_tx
